sccomp: RTL and testbench
=========================

SCCOMP -- requirements
Module: sccomp

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset. The ports SHALL be named clk and rstn, as the codebase does.
REQ-002 Port clk: input, 1 bit, system clock; all state updates on the rising edge.
REQ-003 Port rstn: input, 1 bit, asynchronous active-low reset.
REQ-004 Port reg_sel: input, 5 bits, selects a register-file entry for debug readback.
REQ-005 Port reg_data: output, 32 bits, combinational value of register rf[reg_sel]; rf[0] always reads 0.
REQ-006 Parameter IM_DEPTH, default 256, gives the instruction ROM depth in words.
REQ-007 Parameter DM_DEPTH, default 256, gives the data RAM depth in words.
REQ-008 Fixed hierarchy for bench access:
- internal nets PC[31:0] and instr[31:0];
- instance U_IM with word array ROM[0:IM_DEPTH-1], loadable by $readmemh;
- instance U_SCPU exposing PC and instr;
- U_SCPU.U_RF with array rf[0:31] of 32-bit words;
- instance U_DM.

Function
REQ-009 Execution SHALL be single-cycle MIPS32: one instruction completes per clk rising edge.
REQ-010 Instruction fetch: instr = ROM[PC[log2(IM_DEPTH)+1:2]], combinational.
REQ-011 Next PC: PC+4 by default.
- beq: PC+4+(signext(imm16)<<2) when rs==rt.
- j: {PC+4[31:28], target26, 2'b00}.
REQ-012 Supported instructions, all with 32-bit wrap-around arithmetic and no overflow trap:
- lui (0x0F): rt = {imm16, 16'h0}.
- ori (0x0D): rt = rs | zeroext(imm).
- addi (0x08): rt = rs + signext(imm).
- R-type (op 0x00): add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed compare), with rd as destination.
REQ-013 lw (0x23) and sw (0x2B) use address rs+signext(imm). The word index is addr[log2(DM_DEPTH)+1:2]; the low two address bits are ignored.
REQ-014 Register-file behaviour:
- Writes occur on the clk rising edge.
- Writes to rf[0] are discarded.
- Reads are combinational.
- A read of the register being written in the same cycle returns the old value.
REQ-015 Any unlisted opcode or funct SHALL execute as a NOP that only advances PC by 4.
REQ-016 A PC beyond the ROM range wraps modulo the ROM size through index truncation.

Reset
REQ-017 While rstn=0: PC=0 and rf[1..31]=0, asynchronously. This forces reg_data=0.
REQ-018 The first instruction fetched after rstn deasserts comes from ROM[0]. Reset asserted mid-program aborts the current instruction with no register write.
REQ-019 ROM and data RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-020 Macro SCCOMP_MEMOP_EN:
- Defined: lw/sw and the U_DM instance exist.
- Undefined: U_DM is omitted, and lw/sw execute as NOPs with no register write.

Structure
REQ-021 A shared package sccomp_pkg SHALL hold the opcode and funct constants and the ALU-operation enumeration.
REQ-022 Sub-modules:
- sccpu (U_SCPU): datapath and control, containing the register file rf32 (U_RF);
- im (U_IM): instruction ROM;
- dm (U_DM): data RAM.
- The natural single extra sub-module is rf32.

Verification
REQ-023 lui test:
- Stimulus: ROM[0]=3C011234 (lui $1,0x1234), ROM[1]=34215678 (ori $1,$1,0x5678); pulse rstn low; run 2 cycles.
- Required response: rf[1]=12345678, reg_sel=1 -> reg_data=12345678, PC=00000008.
REQ-024 Arithmetic and zero register:
- Stimulus: addi $2,$0,-1 (2002FFFF); add $3,$2,$2; addi $0,$0,5.
- Required response: rf[2]=FFFFFFFF, rf[3]=FFFFFFFE, rf[0] stays 0.
REQ-025 Branch and jump:
- Stimulus: beq $0,$0,+2 at PC 0.
- Required response: next PC=0000000C.
- Stimulus: j 0x12 (08000012).
- Required response: PC=00000048.
REQ-026 Memory (SCCOMP_MEMOP_EN defined):
- Stimulus: sw $1,8($0), then lw $4,8($0).
- Required response: rf[4] equals rf[1].
REQ-027 Reset mid-run:
- Stimulus: assert rstn=0 asynchronously between clock edges.
- Required response: PC=0 and all rf entries 0 immediately; execution restarts at ROM[0] after release.

Source files
------------

// File: rtl/sccomp_pkg.sv
// Shared MIPS32 subset constants and ALU helper for the single-cycle computer.
package sccomp_pkg;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt, AluLui} alu_op_e;

  function automatic logic [31:0] alu_calc(alu_op_e op, logic [31:0] a, logic [31:0] b);
    logic [31:0] res;
    res = a + b;
    case (op)
      AluSub: res = a - b;
      AluAnd: res = a & b;
      AluOr:  res = a | b;
      AluSlt: res = {31'b0, $signed(a) < $signed(b)};
      AluLui: res = {b[15:0], 16'h0000};
      default: res = a + b;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dm.sv
// Data RAM: synchronous word write, combinational read, no reset of contents.
module dm #(
  parameter int unsigned DM_DEPTH = 256,
  localparam int unsigned Dw = $clog2(DM_DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [Dw-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] RAM [0:DM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) RAM[i_addr] <= i_wdata;
  end

  assign o_rdata = RAM[i_addr];

endmodule

// File: rtl/im.sv
// Instruction ROM, combinational read; contents are loaded externally and survive reset.
module im #(
  parameter int unsigned IM_DEPTH = 256,
  localparam int unsigned Iw = $clog2(IM_DEPTH)
) (
  input  logic [Iw-1:0] i_addr,
  output logic [31:0]   o_dout
);

  logic [31:0] ROM [0:IM_DEPTH-1];

  assign o_dout = ROM[i_addr];

endmodule

// File: rtl/rf32.sv
// 32x32 register file: two operand reads, one debug read, one write port; rf[0] reads zero.
module rf32 (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic [4:0]  i_ra3,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  output logic [31:0] o_rd3
);

  logic [31:0] rf [0:31];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
    end else if (i_we && (i_wa != 5'd0)) begin
      rf[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'h0 : rf[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'h0 : rf[i_ra2];
  assign o_rd3 = (i_ra3 == 5'd0) ? 32'h0 : rf[i_ra3];

endmodule

// File: rtl/sccpu.sv
// Single-cycle MIPS32-subset datapath and control. lw/sw decode only with SCCOMP_MEMOP_EN.
module sccpu
  import sccomp_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] instr,
  output logic [31:0] PC,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic [4:0]  i_reg_sel,
  output logic [31:0] o_reg_data
);

  logic [31:0] r_pc;
  logic [31:0] w_pc4, w_pc_next, w_simm, w_zimm, w_rd1, w_rd2, w_alu_b, w_alu_res, w_wd;
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_dst;
  logic        w_reg_we, w_mem_we;
  alu_op_e     w_alu_op;

  assign w_op    = instr[31:26];
  assign w_rs    = instr[25:21];
  assign w_rt    = instr[20:16];
  assign w_rd    = instr[15:11];
  assign w_funct = instr[5:0];
  assign w_simm  = {{16{instr[15]}}, instr[15:0]};
  assign w_zimm  = {16'h0000, instr[15:0]};
  assign w_pc4   = r_pc + 32'd4;

`ifdef SCCOMP_MEMOP_EN
  logic w_load;
`endif

  always_comb begin
    w_reg_we  = 1'b0;
    w_mem_we  = 1'b0;
    w_dst     = w_rt;
    w_alu_op  = AluAdd;
    w_alu_b   = w_rd2;
    w_pc_next = w_pc4;
`ifdef SCCOMP_MEMOP_EN
    w_load    = 1'b0;
`endif
    case (w_op)
      OpRtype: begin
        w_dst    = w_rd;
        w_reg_we = 1'b1;
        case (w_funct)
          FnAdd:   w_alu_op = AluAdd;
          FnSub:   w_alu_op = AluSub;
          FnAnd:   w_alu_op = AluAnd;
          FnOr:    w_alu_op = AluOr;
          FnSlt:   w_alu_op = AluSlt;
          default: w_reg_we = 1'b0;
        endcase
      end
      OpLui:  begin w_reg_we = 1'b1; w_alu_op = AluLui; w_alu_b = w_zimm; end
      OpOri:  begin w_reg_we = 1'b1; w_alu_op = AluOr;  w_alu_b = w_zimm; end
      OpAddi: begin w_reg_we = 1'b1; w_alu_op = AluAdd; w_alu_b = w_simm; end
      OpBeq:  if (w_rd1 == w_rd2) w_pc_next = w_pc4 + {w_simm[29:0], 2'b00};
      OpJ:    w_pc_next = {w_pc4[31:28], instr[25:0], 2'b00};
`ifdef SCCOMP_MEMOP_EN
      OpLw:   begin w_reg_we = 1'b1; w_load = 1'b1; end
      OpSw:   w_mem_we = 1'b1;
`endif
      default: ;
    endcase
  end

  assign w_alu_res = alu_calc(w_alu_op, w_rd1, w_alu_b);

`ifdef SCCOMP_MEMOP_EN
  assign w_wd = w_load ? i_mem_rdata : w_alu_res;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^i_mem_rdata;
  assign w_wd = w_alu_res;
`endif

  assign o_mem_we    = w_mem_we;
  assign o_mem_addr  = w_rd1 + w_simm;
  assign o_mem_wdata = w_rd2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_pc <= 32'h0;
    else       r_pc <= w_pc_next;
  end

  assign PC = r_pc;

  rf32 U_RF (
    .clk   (clk),
    .rstn  (rstn),
    .i_ra1 (w_rs),
    .i_ra2 (w_rt),
    .i_ra3 (i_reg_sel),
    .i_we  (w_reg_we),
    .i_wa  (w_dst),
    .i_wd  (w_wd),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .o_rd3 (o_reg_data)
  );

endmodule

// File: rtl/sccomp.sv
// Single-cycle computer top: CPU, instruction ROM and, with SCCOMP_MEMOP_EN, data RAM.
module sccomp #(
  parameter int unsigned IM_DEPTH = 256,
  parameter int unsigned DM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  reg_sel,
  output logic [31:0] reg_data
);

  localparam int unsigned Iw = $clog2(IM_DEPTH);
  localparam int unsigned Dw = $clog2(DM_DEPTH);

  logic [31:0] PC;
  logic [31:0] instr;
  logic        w_mem_we;
  logic [31:0] w_mem_addr, w_mem_wdata, w_mem_rdata;

  // Out-of-range PCs wrap because only the word-index bits reach the ROM.
  logic w_unused_pc;
  assign w_unused_pc = ^{PC[31:Iw+2], PC[1:0]};

  im #(.IM_DEPTH(IM_DEPTH)) U_IM (
    .i_addr (PC[Iw+1:2]),
    .o_dout (instr)
  );

  sccpu U_SCPU (
    .clk         (clk),
    .rstn        (rstn),
    .instr       (instr),
    .PC          (PC),
    .o_mem_we    (w_mem_we),
    .o_mem_addr  (w_mem_addr),
    .o_mem_wdata (w_mem_wdata),
    .i_mem_rdata (w_mem_rdata),
    .i_reg_sel   (reg_sel),
    .o_reg_data  (reg_data)
  );

`ifdef SCCOMP_MEMOP_EN
  logic w_unused_maddr;
  assign w_unused_maddr = ^{w_mem_addr[31:Dw+2], w_mem_addr[1:0]};

  dm #(.DM_DEPTH(DM_DEPTH)) U_DM (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr[Dw+1:2]),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );
`else
  logic w_unused_mem;
  assign w_unused_mem = ^{w_mem_we, w_mem_addr, w_mem_wdata};
  assign w_mem_rdata  = 32'h0;
`endif

endmodule

// File: tb/tb_sccomp.sv
// Bench for sccomp: directed program checks plus random programs against an ISA-level model.
module tb_sccomp;

  localparam int unsigned IMD = 256;
  localparam int unsigned DMD = 256;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  reg_sel = 5'd0;
  logic [31:0] reg_data;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] mrom [IMD];
  logic [31:0] mdm  [DMD];
  logic [31:0] mrf  [32];
  logic [31:0] mpc;

  sccomp #(.IM_DEPTH(IMD), .DM_DEPTH(DMD)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .reg_sel  (reg_sel),
    .reg_data (reg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) mrf[r] = v;
  endfunction

  // Executes one instruction of the architectural model.
  function automatic void mstep();
    logic [31:0] i, a, b, simm, npc, addr;
    i    = mrom[mpc[9:2]];
    a    = mrf[i[25:21]];
    b    = mrf[i[20:16]];
    simm = {{16{i[15]}}, i[15:0]};
    npc  = mpc + 32'd4;
    addr = a + simm;
    case (i[31:26])
      6'h00: begin
        case (i[5:0])
          6'h20: wr(i[15:11], a + b);
          6'h22: wr(i[15:11], a - b);
          6'h24: wr(i[15:11], a & b);
          6'h25: wr(i[15:11], a | b);
          6'h2A: wr(i[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: ;
        endcase
      end
      6'h0F: wr(i[20:16], {i[15:0], 16'h0000});
      6'h0D: wr(i[20:16], a | {16'h0000, i[15:0]});
      6'h08: wr(i[20:16], a + simm);
      6'h04: if (a == b) npc = npc + (simm << 2);
      6'h02: npc = {npc[31:28], i[25:0], 2'b00};
`ifdef SCCOMP_MEMOP_EN
      6'h23: wr(i[20:16], mdm[addr[9:2]]);
      6'h2B: mdm[addr[9:2]] = b;
`endif
      default: ;
    endcase
    mpc = npc;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [5:0]  fn;
    int          v;
    logic [31:0] w;
    rs  = 5'($urandom_range(0, 7));
    rt  = 5'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    case ($urandom_range(0, 4))
      0: fn = 6'h20;
      1: fn = 6'h22;
      2: fn = 6'h24;
      3: fn = 6'h25;
      default: fn = 6'h2A;
    endcase
    v = int'($urandom_range(0, 8)) - 4;
    case ($urandom_range(0, 9))
      0: w = {6'h0F, 5'd0, rt, imm};
      1: w = {6'h0D, rs, rt, imm};
      2: w = {6'h08, rs, rt, imm};
      3, 4: w = {6'h00, rs, rt, rd, 5'd0, fn};
      5: w = {6'h04, rs, rt, v[15:0]};
      6: w = {6'h02, 26'($urandom_range(0, 300))};
      7: w = {6'h23, rs, rt, imm};
      8: w = {6'h2B, rs, rt, imm};
      default: w = $urandom;
    endcase
    return w;
  endfunction

  task automatic set_rom(input int a, input logic [31:0] w);
    dut.U_IM.ROM[a] = w;
    mrom[a] = w;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < int'(IMD); i++) set_rom(i, 32'h0);
  endtask

  task automatic model_reset();
    mpc = 32'h0;
    for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    mstep();
    reg_sel = 5'($urandom);
    #1;
    chk("pc", dut.PC, mpc);
    chk($sformatf("reg_data[%0d]", reg_sel), reg_data, mrf[reg_sel]);
  endtask

  task automatic chk_all_rf(input string tag);
    for (int i = 0; i < 32; i++)
      chk($sformatf("%s rf[%0d]", tag, i), dut.U_SCPU.U_RF.rf[i], mrf[i]);
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < int'(DMD); i++) mdm[i] = 32'h0;
`ifdef SCCOMP_MEMOP_EN
    for (int i = 0; i < int'(DMD); i++) dut.U_DM.RAM[i] = 32'h0;
`endif
    clear_rom();
    reg_sel = 5'd7;
    #1;
    chk("reset pc", dut.PC, 32'h0);
    chk("reset reg_data", reg_data, 32'h0);
    chk_all_rf("reset");

    // lui/ori
    clear_rom();
    set_rom(0, 32'h3C011234);
    set_rom(1, 32'h34215678);
    do_reset();
    cycle();
    cycle();
    chk("lui rf1", dut.U_SCPU.U_RF.rf[1], 32'h12345678);
    reg_sel = 5'd1;
    #1;
    chk("lui reg_data", reg_data, 32'h12345678);
    chk("lui pc", dut.PC, 32'h00000008);

    // arithmetic and zero register
    clear_rom();
    set_rom(0, 32'h2002FFFF);
    set_rom(1, 32'h00421820);
    set_rom(2, 32'h20000005);
    do_reset();
    repeat (3) cycle();
    chk("addi rf2", dut.U_SCPU.U_RF.rf[2], 32'hFFFFFFFF);
    chk("add rf3", dut.U_SCPU.U_RF.rf[3], 32'hFFFFFFFE);
    chk("zero rf0", dut.U_SCPU.U_RF.rf[0], 32'h0);
    reg_sel = 5'd0;
    #1;
    chk("zero reg_data", reg_data, 32'h0);

    // branch then jump
    clear_rom();
    set_rom(0, 32'h10000002);
    set_rom(3, 32'h08000012);
    do_reset();
    cycle();
    chk("beq pc", dut.PC, 32'h0000000C);
    cycle();
    chk("j pc", dut.PC, 32'h00000048);

    // store/load round trip; without memory ops lw leaves rf4 untouched
    clear_rom();
    set_rom(0, 32'h3C011234);
    set_rom(1, 32'h34215678);
    set_rom(2, 32'hAC010008);
    set_rom(3, 32'h8C040008);
    do_reset();
    repeat (4) cycle();
    chk("mem rf1", dut.U_SCPU.U_RF.rf[1], 32'h12345678);
`ifdef SCCOMP_MEMOP_EN
    chk("lw rf4", dut.U_SCPU.U_RF.rf[4], 32'h12345678);
`else
    chk("lw nop rf4", dut.U_SCPU.U_RF.rf[4], 32'h0);
`endif

    // asynchronous reset between edges, then restart from ROM[0]
    do_reset();
    repeat (2) cycle();
    @(negedge clk);
    #2;
    rstn = 1'b0;
    model_reset();
    reg_sel = 5'd1;
    #1;
    chk("midrst pc", dut.PC, 32'h0);
    chk("midrst reg_data", reg_data, 32'h0);
    chk_all_rf("midrst");
    rstn = 1'b1;
    cycle();
    chk("restart pc", dut.PC, 32'h00000004);
    chk("restart rf1", dut.U_SCPU.U_RF.rf[1], 32'h12340000);

    // random programs
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < int'(IMD); i++) set_rom(i, rnd_instr());
      do_reset();
      repeat (150) cycle();
      chk_all_rf($sformatf("rand%0d", p));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
